pmu_dump_streamer: RTL and testbench

//  Consumes the 12 counters of the I-cache and D-cache PMUs (6 each).
//  On a trigger it snapshots them into shadow registers, then streams one frame over a
//  32-bit valid/ready channel for testbench and debug dumping.

---
 rtl/pmu_dump_streamer_pkg.sv | 20 ++
 rtl/pmu_dump_streamer_if.sv | 9 +
 rtl/pmu_dump_streamer_shadow_bank.sv | 17 +
 rtl/pmu_dump_streamer.sv | 68 ++++++
 tb/tb_pmu_dump_streamer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pmu_dump_streamer_pkg.sv
// pmu_pkg: shared PMU frame constants, slot map and streamer state encoding
package pmu_pkg;
  localparam int N_CNT = 12;
  localparam int IDX_W = 4;
  localparam logic [31:0] HEADER = 32'h504D_5530;
  localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(N_CNT);
  localparam int IC_RD_CNT = 0;
  localparam int IC_WR_CNT = 1;
  localparam int IC_RD_MISS = 2;
  localparam int IC_WR_MISS = 3;
  localparam int IC_RD_STALL = 4;
  localparam int IC_WR_STALL = 5;
  localparam int DC_RD_CNT = 6;
  localparam int DC_WR_CNT = 7;
  localparam int DC_RD_MISS = 8;
  localparam int DC_WR_MISS = 9;
  localparam int DC_RD_STALL = 10;
  localparam int DC_WR_STALL = 11;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
endpackage

// File: rtl/pmu_dump_streamer_if.sv
// pmu_dump_streamer_if: 32-bit valid/ready frame channel (valid, data, last from master; ready from slave)
interface pmu_dump_streamer_if;
  logic valid;
  logic [31:0] data;
  logic last;
  logic ready;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/pmu_dump_streamer_shadow_bank.sv
// pmu_shadow_bank: N_CNT x 32 capture registers (load captures d) with indexed read mux rd_idx -> rd_data
module pmu_shadow_bank
  import pmu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [32*N_CNT-1:0]    d,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [31:0]            rd_data
);
  logic [32*N_CNT-1:0] sh;
  always_ff @(posedge clk or posedge rst)
    if (rst) sh <= '0;
    else if (load) sh <= d;
  assign rd_data = (rd_idx < CNT_IDX) ? sh[{rd_idx, 5'd0} +: 32] : '0;
endmodule

// File: rtl/pmu_dump_streamer.sv
// pmu_dump_streamer: snapshot 12 PMU counters on snap_trig and stream header/counters/checksum over out; busy, done, sticky trig_dropped
module pmu_dump_streamer
  import pmu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   snap_trig,
  input  logic [32*N_CNT-1:0]    cnt_in,
  pmu_dump_streamer_if.master    out,
  output logic                   busy,
  output logic                   done,
  output logic                   trig_dropped
);
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [31:0] csum, csum_nxt, sh_data;
  pmu_shadow_bank u_bank (
    .clk(clk), .rst(rst), .load(state == S_IDLE && snap_trig),
    .d(cnt_in), .rd_idx(idx), .rd_data(sh_data)
  );
  // word 0 is the header and stays out of the sum; shadow[idx] is the word after the current one
  assign csum_nxt = (idx != '0) ? csum + out.data : csum;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
      csum <= '0;
      out.valid <= 1'b0;
      out.data <= '0;
      out.last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      trig_dropped <= 1'b0;
    end else begin
      done <= 1'b0;
      if (snap_trig && state != S_IDLE) trig_dropped <= 1'b1;
      case (state)
        S_IDLE:
          if (snap_trig) begin
            state <= S_SEND;
            idx <= '0;
            csum <= '0;
            out.valid <= 1'b1;
            out.data <= HEADER;
            out.last <= 1'b0;
            busy <= 1'b1;
          end
        S_SEND:
          if (out.ready) begin
            if (out.last) begin
              state <= S_DONE;
              out.valid <= 1'b0;
              out.data <= '0;
              out.last <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              csum <= csum_nxt;
              out.data <= (idx == CNT_IDX) ? csum_nxt : sh_data;
              out.last <= idx == CNT_IDX;
            end
          end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_pmu_dump_streamer.sv
// tb_pmu_dump_streamer: scoreboard bench for pmu_dump_streamer with a frame-level reference model
module tb_pmu_dump_streamer;
  import pmu_pkg::*;
  logic clk = 0, rst = 0, snap_trig = 0;
  logic [32*N_CNT-1:0] cnt_in = '0;
  logic busy, done, trig_dropped;
  pmu_dump_streamer_if bus();
  pmu_dump_streamer dut (
    .clk(clk), .rst(rst), .snap_trig(snap_trig), .cnt_in(cnt_in),
    .out(bus), .busy(busy), .done(done), .trig_dropped(trig_dropped)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0;
  logic [32:0] exp_q[$];
  int ready_mode = 0, rcnt = 0, accepts = 0, done_chk = 0;
  logic prev_stall = 0;
  logic [32:0] prev_word;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    rcnt++;
    case (ready_mode)
      0: bus.ready = 1'b1;
      1: bus.ready = (rcnt % 3 == 0);
      default: bus.ready = 1'($urandom_range(0, 1));
    endcase
  end
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      done_chk = 0;
    end else begin
      if (prev_stall) chk("hold", {bus.valid, bus.last, bus.data}, {1'b1, prev_word});
      if (done_chk == 1) begin
        chk("done_pulse", {done, bus.valid, busy}, 3'b100);
        done_chk = 2;
      end else if (done_chk == 2) begin
        chk("done_width", done, 0);
        done_chk = 0;
      end
      if (bus.valid) chk("busy_in_send", busy, 1);
      if (bus.valid && bus.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_word: got %0h expected none", bus.data);
        end else chk("word", {bus.last, bus.data}, exp_q.pop_front());
        accepts++;
        if (bus.last) done_chk = 1;
      end
      prev_stall = bus.valid && !bus.ready;
      prev_word = {bus.last, bus.data};
    end
  end
  task automatic start_frame(input logic [31:0] s[N_CNT]);
    logic [31:0] sum = 0;
    exp_q.push_back({1'b0, HEADER});
    for (int k = 0; k < N_CNT; k++) begin
      exp_q.push_back({1'b0, s[k]});
      sum += s[k];
    end
    exp_q.push_back({1'b1, sum});
    @(posedge clk);
    #2;
    for (int k = 0; k < N_CNT; k++) cnt_in[32*k +: 32] = s[k];
    snap_trig = 1;
    @(posedge clk);
    #2 snap_trig = 0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 1000);
    chk("done_seen", done, 1);
  endtask
  task automatic wait_acc(input int n);
    int c = 0;
    while (accepts < n && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("accept_timeout", accepts >= n, 1);
  endtask
  logic [31:0] s[N_CNT];
  int cyc, base;
  initial begin
    #1 rst = 1;
    #2;
    chk("rst_outputs", {bus.valid, bus.last, bus.data, busy, done, trig_dropped}, '0);
    repeat (3) @(posedge clk);
    #2 rst = 0;
    // T1 basic frame, full throughput
    for (int k = 0; k < N_CNT; k++) s[k] = k + 1;
    start_frame(s);
    wait_done(cyc);
    chk("t1_latency", cyc, 15);
    // T2 backpressure: fixed 1,0,0 pattern then random ready with random counters
    ready_mode = 1;
    for (int k = 0; k < N_CNT; k++) s[k] = $urandom;
    start_frame(s);
    wait_done(cyc);
    ready_mode = 2;
    repeat (3) begin
      for (int k = 0; k < N_CNT; k++) s[k] = $urandom;
      start_frame(s);
      wait_done(cyc);
    end
    // T3 live counters change during the frame
    for (int k = 0; k < N_CNT; k++) s[k] = $urandom;
    start_frame(s);
    repeat (2) @(posedge clk);
    cnt_in = '1;
    wait_done(cyc);
    // T4 triggers while busy and in the done cycle
    ready_mode = 0;
    chk("t4_no_drop_yet", trig_dropped, 0);
    for (int k = 0; k < N_CNT; k++) s[k] = 32'h100 * k + 7;
    base = accepts;
    start_frame(s);
    wait_acc(base + 5);
    snap_trig = 1;
    @(posedge clk);
    #2 snap_trig = 0;
    @(negedge clk);
    chk("t4_dropped_send", trig_dropped, 1);
    wait_done(cyc);
    snap_trig = 1;
    @(posedge clk);
    #2 snap_trig = 0;
    repeat (5) @(negedge clk);
    chk("t4_no_second", {bus.valid, busy, trig_dropped}, 3'b001);
    chk("t4_queue_empty", exp_q.size(), 0);
    // T5 checksum wraps to zero
    for (int k = 0; k < N_CNT; k++) s[k] = 32'h8000_0000;
    start_frame(s);
    wait_done(cyc);
    // T6 asynchronous reset mid-frame
    for (int k = 0; k < N_CNT; k++) s[k] = $urandom;
    base = accepts;
    start_frame(s);
    wait_acc(base + 7);
    #2 rst = 1;
    #1;
    chk("t6_async_rst", {bus.valid, bus.last, bus.data, busy, done, trig_dropped}, '0);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 0;
    for (int k = 0; k < N_CNT; k++) s[k] = $urandom;
    start_frame(s);
    wait_done(cyc);
    chk("t6_latency", cyc, 15);
    chk("t6_trig_dropped", trig_dropped, 0);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
